// File: rtl/ripple_carry_add_sub_if.sv
// ripple_carry_add_sub_if: operand/result bundle for ripple_carry_add_sub (RCA_STICKY_OVF_EN adds ovf_clr/ovf_sticky)
interface ripple_carry_add_sub_if #(parameter int WIDTH = 32);
  logic Cin;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic Cout;
  logic V;
  logic [WIDTH-1:0] S_q;
  logic [3:0] ZCNVFlags;
`ifdef RCA_STICKY_OVF_EN
  logic ovf_clr;
  logic ovf_sticky;
  modport master(output Cin, A, B, ovf_clr, input S, Cout, V, S_q, ZCNVFlags, ovf_sticky);
  modport slave(input Cin, A, B, ovf_clr, output S, Cout, V, S_q, ZCNVFlags, ovf_sticky);
`else
  modport master(output Cin, A, B, input S, Cout, V, S_q, ZCNVFlags);
  modport slave(input Cin, A, B, output S, Cout, V, S_q, ZCNVFlags);
`endif
endinterface

// File: rtl/ripple_carry_add_sub.sv
// ripple_carry_add_sub: ripple-carry add/sub with registered sum and ZCNV flags (RCA_STICKY_OVF_EN adds sticky overflow)
module ripple_carry_add_sub #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  ripple_carry_add_sub_if.slave bus
);
  logic [WIDTH:0] c;
  logic [WIDTH-1:0] s;
  logic v;
  assign c[0] = bus.Cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic b;
    assign b = bus.B[i] ^ bus.Cin;
    assign s[i] = bus.A[i] ^ b ^ c[i];
    assign c[i+1] = (bus.A[i] & b) | (c[i] & (bus.A[i] ^ b));
  end
  assign v = c[WIDTH] ^ c[WIDTH-1];
  assign bus.S = s;
  assign bus.Cout = c[WIDTH];
  assign bus.V = v;
  // Capture sum and condition codes every cycle; C is inverted on subtract to read as borrow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.S_q <= '0;
      bus.ZCNVFlags <= 4'b0000;
    end else begin
      bus.S_q <= s;
      bus.ZCNVFlags <= {~|s, c[WIDTH] ^ bus.Cin, s[WIDTH-1], v};
    end
  end
`ifdef RCA_STICKY_OVF_EN
  // Sticky overflow: a new overflow on the same edge beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.ovf_sticky <= 1'b0;
    else bus.ovf_sticky <= v | (bus.ovf_sticky & ~bus.ovf_clr);
  end
`endif
endmodule

// File: tb/tb_ripple_carry_add_sub.sv
// tb_ripple_carry_add_sub: table-driven and random scoreboard bench for ripple_carry_add_sub
module tb_ripple_carry_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  ripple_carry_add_sub_if #(.WIDTH(32)) bus();
  ripple_carry_add_sub #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic cout;
    logic v;
    logic [3:0] f;
  } vec_t;
  typedef struct {
    logic [31:0] s;
    logic [3:0] f;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[8];
`ifdef RCA_STICKY_OVF_EN
  logic clr = 1'b0;
  logic sticky_m = 1'b0;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t model(input logic cin, input logic [31:0] a, input logic [31:0] b);
    vec_t r;
    logic [32:0] full;
    full = {1'b0, a} + {1'b0, cin ? ~b : b} + 33'(cin);
    r.cin = cin;
    r.a = a;
    r.b = b;
    r.s = full[31:0];
    r.cout = full[32];
    r.v = cin ? (a[31] != b[31] && r.s[31] != a[31]) : (a[31] == b[31] && r.s[31] != a[31]);
    r.f = {r.s == 32'd0, cin ? (a < b) : full[32], r.s[31], r.v};
    return r;
  endfunction
  task automatic step(input vec_t e, input string name);
    exp_t x;
    @(negedge clk);
    bus.Cin = e.cin;
    bus.A = e.a;
    bus.B = e.b;
`ifdef RCA_STICKY_OVF_EN
    bus.ovf_clr = clr;
`endif
    #1;
    chk({name, " S"}, bus.S, e.s);
    chk({name, " Cout"}, 32'(bus.Cout), 32'(e.cout));
    chk({name, " V"}, 32'(bus.V), 32'(e.v));
    sb.push_back('{s: e.s, f: e.f});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({name, " S_q"}, bus.S_q, x.s);
    chk({name, " flags"}, 32'(bus.ZCNVFlags), 32'(x.f));
`ifdef RCA_STICKY_OVF_EN
    sticky_m = e.v | (sticky_m & ~clr);
    chk({name, " sticky"}, 32'(bus.ovf_sticky), 32'(sticky_m));
`endif
  endtask
  initial begin
    tbl[0] = '{1'b0, 32'h00001000, 32'h00000004, 32'h00001004, 1'b0, 1'b0, 4'b0000};
    tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 4'b1100};
    tbl[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 4'b0011};
    tbl[3] = '{1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 4'b1000};
    tbl[4] = '{1'b1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 4'b0110};
    tbl[5] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 4'b0001};
    tbl[6] = '{1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0110};
    tbl[7] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 4'b1101};
    bus.Cin = 1'b0;
    bus.A = '0;
    bus.B = '0;
`ifdef RCA_STICKY_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    #1;
    chk("reset S_q", bus.S_q, 32'd0);
    chk("reset flags", 32'(bus.ZCNVFlags), 32'd0);
    bus.A = 32'd1;
    bus.B = 32'd2;
    #1;
    chk("comb in reset", bus.S, 32'd3);
    @(posedge clk);
    #1;
    chk("reset hold S_q", bus.S_q, 32'd0);
    chk("reset hold flags", 32'(bus.ZCNVFlags), 32'd0);
`ifdef RCA_STICKY_OVF_EN
    chk("reset sticky", 32'(bus.ovf_sticky), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(tbl[i], $sformatf("vec%0d", i));
    step(tbl[2], "preload");
    #2;
    rst = 1'b1;
    #1;
    chk("async S_q", bus.S_q, 32'd0);
    chk("async flags", 32'(bus.ZCNVFlags), 32'd0);
    bus.Cin = 1'b0;
    bus.A = 32'd10;
    bus.B = 32'd20;
    #1;
    chk("async comb S", bus.S, 32'd30);
    @(posedge clk);
    #1;
    chk("async hold S_q", bus.S_q, 32'd0);
`ifdef RCA_STICKY_OVF_EN
    chk("async sticky", 32'(bus.ovf_sticky), 32'd0);
    sticky_m = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
    step(tbl[0], "post-reset");
`ifdef RCA_STICKY_OVF_EN
    step(tbl[2], "sticky set");
    step(tbl[0], "sticky hold");
    clr = 1'b1;
    step(tbl[0], "sticky clr");
    step(tbl[5], "sticky clr+ovf");
    clr = 1'b0;
    step(tbl[3], "sticky hold2");
`endif
    for (int i = 0; i < 10000; i++) begin
`ifdef RCA_STICKY_OVF_EN
      clr = ($urandom_range(0, 15) == 0);
`endif
      step(model(1'($urandom_range(0, 1)), $urandom, $urandom), $sformatf("rnd%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_carry_add_sub.md
Name: ripple_carry_add_sub

Overview:
- Parameterised ripple-carry adder/subtractor; 32-bit by default.
- Combinational sum/carry path feeds the PC updater (add-only, Cin=0) and the ALU (add/sub).
- Also registers a ZCNV flag word plus the sum for consumers that need stable, clocked condition codes (branch compare).

Parameters:
- WIDTH, 32, operand/result bit width (≥2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- Cin  input  1  operation select and LSB carry-in: 0 = add (A+B), 1 = subtract (A+~B+1).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- S  output  WIDTH  combinational result.
- Cout  output  1  combinational raw carry out of the MSB stage.
- V  output  1  combinational signed overflow.
- S_q  output  WIDTH  registered copy of S.
- ZCNVFlags  output  4  registered flags, packed [3]=Z, [2]=C, [1]=N, [0]=V.
- Interface constraint (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Datapath is a true ripple chain of WIDTH one-bit full-adder cells (generate loop).
  - Bit i operand is B[i]^Cin.
  - Carry into bit 0 is Cin; carry into bit i+1 is the carry out of bit i.
  - No lookahead or "+" operator on the full word.
- S, Cout and V are purely combinational from A, B, Cin, with zero cycle latency.
  - They are independent of clk and rst, including while rst is asserted.
- S is the result modulo 2^WIDTH; wrap-around is silent.
- Cout is the carry out of bit WIDTH-1 (raw: 1 on add overflow, 1 on subtract with no borrow).
- V = carry into MSB XOR carry out of MSB.
- Register stage: on each rising clk, S_q <= S and ZCNVFlags are updated as follows.
  - Z = (S == 0).
  - C = Cout ^ Cin, so C is unsigned carry for add and borrow for subtract (1 means A < B unsigned).
  - N = S[WIDTH-1].
  - V = V.
- Flag consumers use: BEQ Z=1, BNE Z=0, BLT N^V=1, BGE N^V=0, BLTU C=1, BGEU C=0.
- Reset: rst=1 immediately (asynchronously) forces S_q=0 and ZCNVFlags=4'b0000.
  - Registers hold reset while rst is high.
  - The first capture occurs on the first rising clk after rst deasserts.
  - Reset asserted mid-operation discards the pending value; the combinational outputs are unaffected.
- No enable: registers capture every cycle.
- Inputs changing between edges affect only the combinational outputs until the next edge.
- X/Z on inputs are not handled specially.

Optional Feature:
- Macro: RCA_STICKY_OVF_EN.
- Defined:
  - Adds output port ovf_sticky (1 bit) and input port ovf_clr (1 bit).
  - ovf_sticky is set on a rising clk when V=1 and stays set.
  - It is cleared by rst (asynchronously) or by ovf_clr=1 at a rising clk.
  - If ovf_clr and V=1 occur on the same edge, set wins (ovf_sticky=1).
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Add: Cin=0, A=0x00001000, B=0x00000004 -> S=0x00001004, Cout=0, V=0; after clk ZCNVFlags=4'b0000, S_q=0x00001004.
- Unsigned wrap: Cin=0, A=0xFFFFFFFF, B=0x00000001 -> S=0, Cout=1, V=0; after clk Z=1, C=1, N=0, V=0.
- Signed overflow: Cin=0, A=0x7FFFFFFF, B=0x00000001 -> S=0x80000000, V=1; after clk flags 4'b0011.
- Subtract equal/less:
  - Cin=1, A=5, B=5 -> S=0, Cout=1; flags Z=1, C=0.
  - Cin=1, A=3, B=5 -> S=0xFFFFFFFE, Cout=0; flags C=1, N=1, V=0, so BLT and BLTU are both taken.
  - Cin=1, A=0x80000000, B=1 -> S=0x7FFFFFFF, V=1.
- Async reset: load nonzero flags, assert rst between clock edges -> S_q=0 and ZCNVFlags=0 without waiting for an edge, while S still tracks A/B.
- Randomised: 10k random A/B/Cin -> S, Cout, V match a behavioural reference every cycle; with RCA_STICKY_OVF_EN, ovf_sticky latches on the first V=1 and clears only via ovf_clr or rst.
